// File: rtl/sbox_share_arbiter_if.sv
// sbox_share_arbiter_if: request fan-in and tagged response bundle for sbox_share_arbiter
interface sbox_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [8*N_REQ-1:0] req_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [7:0]         rsp_data;
    logic [ID_W-1:0]    rsp_id;
    modport master (output req_valid, req_data, rsp_ready, input req_ready, rsp_valid, rsp_data, rsp_id);
    modport slave (input req_valid, req_data, rsp_ready, output req_ready, rsp_valid, rsp_data, rsp_id);
endinterface

// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter: round-robin sharing of one AES S-box among N_REQ byte requesters, 2-stage pipe
// Define SBOX_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin group.
module sbox_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    sbox_share_arbiter_if.slave bus,
    output logic                busy
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p = b[k] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    function automatic logic [7:0] gsq(input logic [7:0] a);
        return gmul(a, a);
    endfunction
    // Inverse via the GF(2^4) subfield: a^17 is the norm, inverted as n^14, then a^-1 = a^16 * n^14
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a16;
        logic [7:0] n;
        logic [7:0] n2;
        logic [7:0] n4;
        logic [7:0] v;
        a16 = gsq(gsq(gsq(gsq(a))));
        n   = gmul(a16, a);
        n2  = gsq(n);
        n4  = gsq(n2);
        v   = gmul(a16, gmul(gmul(gsq(n4), n4), n2));
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction
    logic [ID_W-1:0] rr_ptr;
    logic            s0_v;
    logic [7:0]      s0_data;
    logic [ID_W-1:0] s0_id;
    logic            s1_v;
    logic [7:0]      s1_data;
    logic [ID_W-1:0] s1_id;
    logic            adv;
    logic            gnt_v;
    logic [ID_W-1:0] gnt_id;
    logic [7:0]      gnt_data;
    logic            rr_upd;
    logic [ID_W-1:0] rr_nxt;
    logic [7:0]      sbox_out;
    assign adv = !s1_v || bus.rsp_ready;
    always_comb begin
        gnt_v  = 1'b0;
        gnt_id = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                gnt_v  = 1'b1;
                gnt_id = ID_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
`ifdef SBOX_ARB_PRIO0_EN
        gnt_v  = gnt_v || bus.req_valid[0];
        gnt_id = bus.req_valid[0] ? '0 : gnt_id;
`endif
    end
`ifdef SBOX_ARB_PRIO0_EN
    assign rr_upd = gnt_v && gnt_id != '0;
`else
    assign rr_upd = gnt_v;
`endif
    assign rr_nxt        = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    assign gnt_data      = bus.req_data[8*int'(gnt_id) +: 8];
    assign bus.req_ready = (gnt_v && adv && rst_n) ? N_REQ'(1) << gnt_id : '0;
    assign sbox_out      = sbox(s0_data);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            s0_v    <= 1'b0;
            s0_data <= '0;
            s0_id   <= '0;
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_id   <= '0;
        end else if (adv) begin
            rr_ptr  <= rr_upd ? rr_nxt : rr_ptr;
            s0_v    <= gnt_v;
            s0_data <= gnt_data;
            s0_id   <= gnt_id;
            s1_v    <= s0_v;
            s1_data <= sbox_out;
            s1_id   <= s0_id;
        end
    end
    assign bus.rsp_valid = s1_v;
    assign bus.rsp_data  = s1_data;
    assign bus.rsp_id    = s1_id;
    assign busy          = s0_v || s1_v;
endmodule

// File: tb/tb_sbox_share_arbiter.sv
// tb_sbox_share_arbiter: directed and random stimulus against a queue-based reference model
module tb_sbox_share_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
`ifdef SBOX_ARB_PRIO0_EN
    localparam logic PRIO = 1'b1;
`else
    localparam logic PRIO = 1'b0;
`endif
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    logic clk;
    logic rst_n;
    logic busy;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ptr = 0;
    int   pipe[$] = '{-1, -1};
    int   last_acc = -1;
    int   cnt;
    logic [7:0] d;
    sbox_share_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus ();
    sbox_share_arbiter #(.N_REQ(N), .ID_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic int model_grant(input logic [N-1:0] vld, input int p);
        if (PRIO && vld[0]) return 0;
        for (int k = 0; k < N; k++) if (vld[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction
    // pipe[0] is the newest in-flight entry, pipe[1] is what the response port shows; -1 is a bubble
    task automatic cycle();
        int g;
        logic adv;
        logic [N-1:0] er;
        #1;
        adv = pipe[1] < 0 || bus.rsp_ready;
        g = model_grant(bus.req_valid, ptr);
        er = (adv && g >= 0) ? N'(1) << g : '0;
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(pipe[1] >= 0));
        chk("busy", 32'(busy), 32'(pipe[0] >= 0 || pipe[1] >= 0));
        if (pipe[1] >= 0) begin
            chk("rsp_data", 32'(bus.rsp_data), 32'(SBOX[pipe[1] % 256]));
            chk("rsp_id", 32'(bus.rsp_id), 32'(pipe[1] / 256));
        end
        last_acc = (adv && g >= 0) ? g : -1;
        if (adv) begin
            void'(pipe.pop_back());
            pipe.push_front(last_acc < 0 ? -1 : last_acc * 256 + int'(bus.req_data[8*last_acc +: 8]));
            if (last_acc >= 0 && !(PRIO && last_acc == 0)) ptr = (last_acc + 1) % N;
        end
        @(negedge clk);
    endtask
    task automatic drain();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) cycle();
    endtask
    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        bus.req_valid = '1;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        // single byte 0x00 from requester 0
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        cycle();
        bus.req_valid = '0;
        cycle();
        #1;
        chk("t1_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t1_data", 32'(bus.rsp_data), 32'h63);
        chk("t1_id", 32'(bus.rsp_id), 32'h0);
        cycle();
        // full byte sweep from requester 2
        d = 8'h00;
        cnt = 0;
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 256; c++) begin
            bus.req_data[23:16] = d;
            cycle();
            if (last_acc == 2) begin
                d++;
                cnt++;
            end
        end
        chk("sweep_count", 32'(cnt), 32'd256);
        drain();
        // all requesters busy
        bus.req_valid = 4'b1111;
        bus.req_data = 32'h11223344;
        repeat (9) cycle();
        drain();
        // backpressure on a stream from requester 1
        d = 8'h10;
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 16; c++) begin
            bus.rsp_ready = !(c >= 4 && c < 9);
            bus.req_data[15:8] = d;
            cycle();
            if (last_acc == 1) d++;
        end
        drain();
        // wrap-around from rr_ptr=3
        bus.req_valid = 4'b0100;
        cycle();
        bus.req_valid = 4'b0001;
        #1;
        chk("wrap_grant", 32'(bus.req_ready), 32'h1);
        cycle();
        bus.req_valid = 4'b1110;
        cycle();
        drain();
        // async reset with both stages full
        bus.req_valid = 4'b0010;
        bus.req_data = 32'h00005500;
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_req_ready", 32'(bus.req_ready), 32'h0);
        ptr = 0;
        pipe = '{-1, -1};
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 4'b0110;
        bus.req_data = 32'h0053aa00;
        cycle();
        bus.req_valid = '0;
        cycle();
        #1;
        chk("post_rst_data", 32'(bus.rsp_data), 32'hac);
        chk("post_rst_id", 32'(bus.rsp_id), 32'h1);
        cycle();
        drain();
        // random traffic
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = N'($urandom);
            bus.req_data = $urandom;
            bus.rsp_ready = $urandom_range(3) != 0;
            cycle();
        end
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
